// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer with in-order commit and req/ack drain
module store_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_en1,
   input  logic [AW-1:0]    alloc_addr1,
   input  logic [DW-1:0]    alloc_data1,
   input  logic             alloc_en2,
   input  logic [AW-1:0]    alloc_addr2,
   input  logic [DW-1:0]    alloc_data2,
   input  logic             write1,
   input  logic             write2,
   input  logic             flush,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_data,
   output logic             sb_full,
   output logic             sb_empty,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   head_q, cptr_q, tail_q;
   logic [PTR_W-1:0]   head_d, cptr_d, tail_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [PTR_W:0]     ccnt_q, ccnt_d;
   logic [DEPTH-1:0]   cmt_q, cmt_d;
   logic [AW-1:0]      addr_mem [DEPTH];
   logic [DW-1:0]      data_mem [DEPTH];

   logic               alloc_ok, do1, do2, pop, load;
   logic [PTR_W-1:0]   idx1, idx2, cptr_p1;
   logic [PTR_W:0]     n_alloc, n_req, n_cmt, ucnt;

   assign count    = count_q;
   assign sb_full  = count_q > (DEPTH_C - 2);
   assign sb_empty = (count_q == '0);
   assign mem_req  = (state_q == BUSY);

   // Allocation, commit clipping, flush recovery and pointer/counter next state
   always_comb begin
      alloc_ok = !sb_full && !flush;
      do1      = alloc_en1 && alloc_ok;
      do2      = alloc_en2 && alloc_ok;
      n_alloc  = (PTR_W+1)'(do1) + (PTR_W+1)'(do2);
      idx1     = tail_q;
      idx2     = tail_q + PTR_W'(do1);
      pop      = (state_q == BUSY) && mem_ack;

      // uncommitted entries bound how far cptr may move; it never passes tail
      ucnt     = count_q - ccnt_q;
      n_req    = (PTR_W+1)'(write1) + (PTR_W+1)'(write2);
      n_cmt    = (n_req > ucnt) ? ucnt : n_req;
      cptr_p1  = cptr_q + PTR_W'(1);
      cptr_d   = cptr_q + n_cmt[PTR_W-1:0];
      ccnt_d   = ccnt_q + n_cmt - (PTR_W+1)'(pop);
      head_d   = head_q + PTR_W'(pop);

      if (flush) begin
         // same-cycle commits land first, then every uncommitted entry is dropped
         tail_d  = cptr_d;
         count_d = ccnt_d;
      end else begin
         tail_d  = tail_q + n_alloc[PTR_W-1:0];
         count_d = count_q + n_alloc - (PTR_W+1)'(pop);
      end
   end

   // Committed-bit vector: set on commit, cleared when the head entry is freed
   always_comb begin
      cmt_d = cmt_q;
      if (pop)
         cmt_d[head_q] = 1'b0;
      if (n_cmt >= (PTR_W+1)'(1))
         cmt_d[cptr_q] = 1'b1;
      if (n_cmt == (PTR_W+1)'(2))
         cmt_d[cptr_p1] = 1'b1;
   end

   // Pointer, counter and committed-bit registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         cptr_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ccnt_q  <= '0;
         cmt_q   <= '0;
      end else begin
         head_q  <= head_d;
         cptr_q  <= cptr_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ccnt_q  <= ccnt_d;
         cmt_q   <= cmt_d;
      end
   end

   // Entry payload storage; contents are only meaningful between head and tail
   always_ff @(posedge clk) begin
      if (do1) begin
         addr_mem[idx1] <= alloc_addr1;
         data_mem[idx1] <= alloc_data1;
      end
      if (do2) begin
         addr_mem[idx2] <= alloc_addr2;
         data_mem[idx2] <= alloc_data2;
      end
   end

   // Drain FSM next state: issue the committed head entry, wait for ack
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if ((count_q != '0) && cmt_q[head_q]) begin
               load    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Drain FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Request payload is captured at issue and held for the whole BUSY phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr <= '0;
         mem_data <= '0;
      end else if (load) begin
         mem_addr <= addr_mem[head_q];
         mem_data <= data_mem[head_q];
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_en1, alloc_en2;
   logic [31:0] alloc_addr1, alloc_addr2, alloc_data1, alloc_data2;
   logic        write1, write2, flush, mem_ack;
   logic        mem_req, sb_full, sb_empty;
   logic [31:0] mem_addr, mem_data;
   logic [3:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   store_buffer #(.DEPTH(8), .PTR_W(3), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .alloc_en1(alloc_en1), .alloc_addr1(alloc_addr1), .alloc_data1(alloc_data1),
      .alloc_en2(alloc_en2), .alloc_addr2(alloc_addr2), .alloc_data2(alloc_data2),
      .write1(write1), .write2(write2), .flush(flush), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
      .sb_full(sb_full), .sb_empty(sb_empty), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc2(input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] a2, input logic [31:0] d2);
      alloc_en1 = 1'b1; alloc_addr1 = a1; alloc_data1 = d1;
      alloc_en2 = 1'b1; alloc_addr2 = a2; alloc_data2 = d2;
      step();
      alloc_en1 = 1'b0; alloc_en2 = 1'b0;
   endtask

   task automatic alloc1(input logic [31:0] a1, input logic [31:0] d1);
      alloc_en1 = 1'b1; alloc_addr1 = a1; alloc_data1 = d1;
      step();
      alloc_en1 = 1'b0;
   endtask

   task automatic commit(input int n);
      write1 = 1'b1;
      write2 = (n == 2);
      step();
      write1 = 1'b0; write2 = 1'b0;
   endtask

   task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
      int k = 0;
      while (!mem_req && k < 20) begin
         step();
         k++;
      end
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_addr"}, mem_addr, a);
      check({tag, "_data"}, mem_data, d);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check({tag, "_req_drop"}, mem_req, 0);
   endtask

   initial begin
      rst = 1'b1;
      alloc_en1 = 0; alloc_en2 = 0; alloc_addr1 = 0; alloc_addr2 = 0;
      alloc_data1 = 0; alloc_data2 = 0;
      write1 = 0; write2 = 0; flush = 0; mem_ack = 0;

      // reset state
      #3;
      check("rst_count", count, 0);
      check("rst_empty", sb_empty, 1);
      check("rst_full", sb_full, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      #9 rst = 1'b0;
      step();

      // dual alloc then commit: request one cycle after commit
      alloc2(32'h100, 32'h11, 32'h104, 32'h22);
      check("a2_count", count, 2);
      check("a2_req", mem_req, 0);
      commit(1);
      check("c1_req_early", mem_req, 0);
      step();
      check("c1_req", mem_req, 1);
      check("c1_addr", mem_addr, 32'h100);
      check("c1_data", mem_data, 32'h11);

      // ack delayed 3 cycles: request held stable
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_req", mem_req, 1);
         check("hold_addr", mem_addr, 32'h100);
         check("hold_data", mem_data, 32'h11);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("ack_count", count, 1);
      check("ack_req", mem_req, 0);
      step();
      check("idle_uncommitted_req", mem_req, 0);
      commit(1);
      check("c2_req_early", mem_req, 0);
      step();
      check("c2_req", mem_req, 1);
      check("c2_addr", mem_addr, 32'h104);
      check("c2_data", mem_data, 32'h22);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("c2_count", count, 0);
      check("c2_empty", sb_empty, 1);

      // fill to 7, alloc while full is ignored
      alloc2(32'h200, 32'h1200, 32'h204, 32'h1204);
      alloc2(32'h208, 32'h1208, 32'h20C, 32'h120C);
      alloc2(32'h210, 32'h1210, 32'h214, 32'h1214);
      check("six_full", sb_full, 0);
      alloc1(32'h218, 32'h1218);
      check("seven_count", count, 7);
      check("seven_full", sb_full, 1);
      alloc2(32'hBAD0, 32'hBAD0, 32'hBAD4, 32'hBAD4);
      check("full_ignored_count", count, 7);
      commit(1);
      drain_one("fill0", 32'h200, 32'h1200);
      check("fill_pop_count", count, 6);
      check("fill_pop_full", sb_full, 0);
      for (int i = 1; i < 7; i++) begin
         commit(1);
         drain_one("fill", 32'h200 + 32'(4*i), 32'h1200 + 32'(4*i));
      end
      check("fill_empty", sb_empty, 1);
      alloc1(32'h2F0, 32'h12F0);
      commit(1);
      drain_one("after_full", 32'h2F0, 32'h12F0);
      check("after_full_count", count, 0);

      // flush with same-cycle commit
      alloc2(32'h300, 32'h1300, 32'h304, 32'h1304);
      alloc2(32'h308, 32'h1308, 32'h30C, 32'h130C);
      commit(1);
      flush = 1'b1; write1 = 1'b1;
      alloc_en1 = 1'b1; alloc_addr1 = 32'hDEAD; alloc_data1 = 32'hDEAD;
      step();
      flush = 1'b0; write1 = 1'b0; alloc_en1 = 1'b0;
      check("flush_count", count, 2);
      alloc1(32'h400, 32'h1400);
      check("post_flush_count", count, 3);
      drain_one("fl0", 32'h300, 32'h1300);
      commit(1);
      drain_one("fl1", 32'h304, 32'h1304);
      drain_one("fl2", 32'h400, 32'h1400);
      check("flush_empty", sb_empty, 1);

      // wrap-around rounds
      for (int r = 0; r < 10; r++) begin
         alloc2(32'h500 + 32'(8*r), 32'h1500 + 32'(8*r),
                32'h504 + 32'(8*r), 32'h1504 + 32'(8*r));
         check("wrap_count_bound", (count <= 4'd8), 1);
         commit(2);
         drain_one("wrap_a", 32'h500 + 32'(8*r), 32'h1500 + 32'(8*r));
         drain_one("wrap_b", 32'h504 + 32'(8*r), 32'h1504 + 32'(8*r));
      end
      check("wrap_empty", count, 0);

      // ack while idle is ignored
      mem_ack = 1'b1;
      alloc1(32'h600, 32'h1600);
      mem_ack = 1'b0;
      check("idle_ack_count", count, 1);

      // async reset while BUSY
      alloc2(32'h604, 32'h1604, 32'h608, 32'h1608);
      check("pre_rst_count", count, 3);
      commit(1);
      begin
         int k = 0;
         while (!mem_req && k < 20) begin
            step();
            k++;
         end
      end
      check("pre_rst_req", mem_req, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_req", mem_req, 0);
      check("arst_count", count, 0);
      check("arst_empty", sb_empty, 1);
      step();
      rst = 1'b0;
      step();
      check("post_rst_count", count, 0);
      check("post_rst_req", mem_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Circular store buffer between dispatch/execute and the data cache of the dual-issue out-of-order core.
- Stores are allocated in program order, up to two per cycle.
- The WB/COM stage marks the oldest uncommitted entries as committed through its write1/write2 status-bit write enables.
- Committed entries drain in order to memory through a req/ack handshake. A branch-mispredict flush discards all uncommitted entries.

Parameters:
DEPTH, 8, number of entries (power of two, >=4)
PTR_W, 3, log2(DEPTH)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
alloc_en1  in  1  allocate store slot 1 (older)
alloc_addr1  in  AW  slot 1 store address
alloc_data1  in  DW  slot 1 store data
alloc_en2  in  1  allocate store slot 2 (younger)
alloc_addr2  in  AW  slot 2 store address
alloc_data2  in  DW  slot 2 store data
write1  in  1  commit oldest uncommitted entry (from WB/COM, valid1 & memwen1)
write2  in  1  commit next uncommitted entry (valid2 & memwen2)
flush  in  1  mispredict recovery: drop uncommitted entries
mem_ack  in  1  memory accepted current request
mem_req  out  1  drain request
mem_addr  out  AW  drain address
mem_data  out  DW  drain data
sb_full  out  1  fewer than 2 free entries; dispatch must stall stores
sb_empty  out  1  no entries held
count  out  PTR_W+1  occupied entries

Behaviour:
- Reset (async, rst=1): head/commit/tail pointers=0; count=0; all committed bits=0; drain FSM=IDLE; mem_req=0; mem_addr=0; mem_data=0; sb_full=0; sb_empty=1.
- Pointers:
  - head = oldest entry.
  - cptr = oldest uncommitted entry.
  - tail = next free entry.
  - All pointers wrap modulo DEPTH.
  - Ordering head <= cptr <= tail (circular).
- Allocation:
  - Requests are packed. The slot-1 entry is written at tail, then the slot-2 entry at the following entry. If only alloc_en2 is set, its entry is written at tail.
  - tail advances by the number of allocations.
  - sb_full = (DEPTH - count) < 2, computed from registered count.
  - Allocation while sb_full=1 is ignored: no entry written, tail unchanged.
- Commit:
  - n = write1 + write2 (packed).
  - Entries at cptr and cptr+1 are marked committed; cptr advances by n.
  - A commit request beyond the number of uncommitted entries is clipped; cptr never passes tail.
- Flush:
  - Commits in the same cycle are applied first, then tail := new cptr and count := committed entries.
  - Allocations in a flush cycle are dropped.
  - Committed entries and an in-progress drain are unaffected.
- Drain FSM:
  - IDLE: if count>0 and head entry committed, load mem_addr/mem_data from head, set mem_req=1, go to BUSY. The request appears 1 cycle after the entry is committed.
  - BUSY: mem_req, mem_addr and mem_data are held stable. On mem_ack=1: head advances, count decrements, mem_req=0, go to IDLE.
  - This leaves a minimum 1-cycle bubble between requests; sustained throughput is 1 store per 2 cycles.
- Counter: count_next = count + allocs_accepted - pop, where pop = BUSY & mem_ack. Simultaneous alloc and pop are both applied.
- Status: sb_empty = (count==0). Freed entries clear their committed bit.
- Reset mid-drain: mem_req drops immediately and all entries are lost. Memory must abandon an unacknowledged request when rst is asserted.
- mem_ack outside BUSY is ignored.

Test Plan:
- Reset, then alloc both slots (A=0x100/D=0x11, A=0x104/D=0x22) -> count=2, mem_req=0; assert write1 -> next cycle mem_req=1, mem_addr=0x100, mem_data=0x11.
- Drain with mem_ack delayed 3 cycles -> mem_req/addr/data held stable 3 cycles; after ack count decrements by 1 and mem_req=0 for 1 cycle; when entry 2 is committed, it issues addr 0x104.
- Fill to 7 entries -> sb_full=1; alloc while full -> count stays 7, tail unchanged; one drain completes -> sb_full=0 (6 entries).
- 4 entries with 1 committed, flush plus write1 in the same cycle -> count=2; the next alloc lands at the old third-entry index.
- Wrap-around: 10 alloc/commit/drain rounds at DEPTH=8 -> addresses drain in allocation order across the wrap; count never exceeds 8.
- Assert rst while BUSY with 3 entries -> mem_req=0, count=0, sb_empty=1 asynchronously (before the next clock edge).
